zorro_slave_access: RTL and testbench

//  Parametrised Zorro slave-access controller, generalising the single-region SCSI DTACK generator.

---
 rtl/zorro_slave_access_pkg.sv | 26 ++
 rtl/zorro_region_decode.sv | 47 ++++
 rtl/zorro_slave_access.sv | 191 +++++++++++++++++++
 tb/tb_zorro_slave_access.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/zorro_slave_access_pkg.sv
// ---------------------------------------------------------------------------
// zorro_slave_access_pkg
// Shared definitions for the Zorro slave-access controller:
//   - state encoding of the access FSM (IDLE=0, WAIT_ACK=1, ASSERT_DTACK=2,
//     BUS_ERROR=3)
//   - default decoded address slice and counter widths
//   - helper that sizes a region index so a single region still gets 1 bit
// ---------------------------------------------------------------------------
package zorro_slave_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_ACK     = 2'd1,
        ST_ASSERT_DTACK = 2'd2,
        ST_BUS_ERROR    = 2'd3
    } state_e;

    localparam int DEF_ADDR_HI = 23;
    localparam int DEF_ADDR_LO = 17;
    localparam int WAIT_W      = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zorro_region_decode.sv
// ---------------------------------------------------------------------------
// zorro_region_decode
// Combinational address-window compare with lowest-index priority.
// Ports:
//   addr        in   AW   decoded address slice
//   slave_cycle in   1    cycle targets this card
//   configured  in   1    autoconfig complete
//   hit_any     out  1    some window matched
//   hit_idx     out  IW   lowest matching window index (0 when no hit)
// ---------------------------------------------------------------------------
module zorro_region_decode #(
    parameter int                       NUM_REGIONS = 2,
    parameter int                       AW          = 7,
    parameter int                       IW          = 1,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_SIZE = '0
) (
    input  logic [AW-1:0] addr,
    input  logic          slave_cycle,
    input  logic          configured,
    output logic          hit_any,
    output logic [IW-1:0] hit_idx
);

    logic [AW:0] addr_ext;
    logic [AW:0] lo;
    logic [AW:0] hi;

    // Windows are compared one bit wider so base+size == 2^AW does not wrap.
    // Scanning from the top down lets the lowest matching index win overlaps.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        addr_ext = {1'b0, addr};
        lo       = '0;
        hi       = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            lo = {1'b0, REGION_BASE[i*AW +: AW]};
            hi = lo + {1'b0, REGION_SIZE[i*AW +: AW]};
            if (slave_cycle && configured && (addr_ext >= lo) && (addr_ext < hi)) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/zorro_slave_access.sv
// ---------------------------------------------------------------------------
// zorro_slave_access
// Zorro slave-access controller: decodes NUM_REGIONS address windows, drives
// a one-hot select to the hit device, enforces a per-region minimum wait,
// then waits for that device's active-low ack before raising dtack.
// Optional feature macro: ZORRO_SLAVE_TIMEOUT_EN adds a WAIT_ACK timeout
// that raises berr; without it berr is constant 0 and the wait is unbounded.
// Ports:
//   CLK           in   1     system clock
//   RESET         in   1     synchronous active-high reset
//   ADDR          in   AW    Zorro address bits [ADDR_HI:ADDR_LO]
//   FCS_n         in   1     full cycle strobe, active low
//   slave_cycle   in   1     cycle targets this card
//   configured    in   1     autoconfig complete
//   ACK_n         in   NR    per-device ack, active low
//   dev_cs        out  NR    one-hot device select
//   active_region out  IW    latched region index
//   dtack         out  1     data acknowledge, active high
//   berr          out  1     bus error, active high
// ---------------------------------------------------------------------------
module zorro_slave_access
    import zorro_slave_access_pkg::*;
#(
    parameter int NUM_REGIONS = 2,
    parameter int ADDR_HI     = DEF_ADDR_HI,
    parameter int ADDR_LO     = DEF_ADDR_LO,
    parameter logic [NUM_REGIONS*(ADDR_HI-ADDR_LO+1)-1:0] REGION_BASE = {7'h44, 7'h40},
    parameter logic [NUM_REGIONS*(ADDR_HI-ADDR_LO+1)-1:0] REGION_SIZE = {7'h02, 7'h04},
    parameter logic [NUM_REGIONS*WAIT_W-1:0]              REGION_WAIT = {4'd2, 4'd0},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic [ADDR_HI-ADDR_LO:0]             ADDR,
    input  logic                                 FCS_n,
    input  logic                                 slave_cycle,
    input  logic                                 configured,
    input  logic [NUM_REGIONS-1:0]               ACK_n,
    output logic [NUM_REGIONS-1:0]               dev_cs,
    output logic [idx_width(NUM_REGIONS)-1:0]    active_region,
    output logic                                 dtack,
    output logic                                 berr
);

    localparam int AW = ADDR_HI - ADDR_LO + 1;
    localparam int IW = idx_width(NUM_REGIONS);

    state_e              state;
    state_e              state_next;
    logic                hit_any;
    logic [IW-1:0]       hit_idx;
    logic [IW-1:0]       reg_idx;
    logic [IW-1:0]       cur_idx;
    logic [WAIT_W-1:0]   cnt;
    logic                ack_sel;
    logic [NUM_REGIONS-1:0] dev_cs_d;
    logic                dtack_d;

`ifdef ZORRO_SLAVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to;
    logic          timeout_hit;
    logic          berr_d;

    assign timeout_hit = (to == TW'(TIMEOUT_CYCLES - 1));
`endif

    zorro_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .AW          (AW),
        .IW          (IW),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE)
    ) u_decode (
        .addr        (ADDR),
        .slave_cycle (slave_cycle),
        .configured  (configured),
        .hit_any     (hit_any),
        .hit_idx     (hit_idx)
    );

    // Only the latched device's ack line is observed.
    assign ack_sel = ~ACK_n[reg_idx];

    // Region used for the next registered outputs: the decoder while idle,
    // afterwards the latched index so address changes are ignored.
    assign cur_idx = (state == ST_IDLE) ? hit_idx : reg_idx;

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            dev_cs        <= '0;
            active_region <= '0;
            dtack         <= 1'b0;
            berr          <= 1'b0;
            reg_idx       <= '0;
            cnt           <= '0;
`ifdef ZORRO_SLAVE_TIMEOUT_EN
            to            <= '0;
`endif
        end else begin
            state  <= state_next;
            dev_cs <= dev_cs_d;
            dtack  <= dtack_d;
`ifdef ZORRO_SLAVE_TIMEOUT_EN
            berr   <= berr_d;
`else
            berr   <= 1'b0;
`endif
            if (state == ST_IDLE && state_next == ST_WAIT_ACK) begin
                reg_idx       <= hit_idx;
                active_region <= hit_idx;
                cnt           <= REGION_WAIT[int'(hit_idx)*WAIT_W +: WAIT_W];
`ifdef ZORRO_SLAVE_TIMEOUT_EN
                to            <= '0;
`endif
            end else if (state == ST_WAIT_ACK) begin
                // Both counters saturate instead of wrapping.
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
`ifdef ZORRO_SLAVE_TIMEOUT_EN
                if (to != '1) begin
                    to <= to + 1'b1;
                end
`endif
            end
        end
    end

    // Next-state logic; a released strobe outranks ack, ack outranks timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!FCS_n && hit_any) begin
                    state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (FCS_n) begin
                    state_next = ST_IDLE;
                end else if (cnt == '0 && ack_sel) begin
                    state_next = ST_ASSERT_DTACK;
                end
`ifdef ZORRO_SLAVE_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = ST_BUS_ERROR;
                end
`endif
            end
            ST_ASSERT_DTACK: begin
                if (FCS_n) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef ZORRO_SLAVE_TIMEOUT_EN
            ST_BUS_ERROR: begin
                if (FCS_n) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Output values to register, decoded from the next state.
    always_comb begin
        dev_cs_d = '0;
        dtack_d  = 1'b0;
`ifdef ZORRO_SLAVE_TIMEOUT_EN
        berr_d   = 1'b0;
`endif
        if (state_next == ST_WAIT_ACK || state_next == ST_ASSERT_DTACK) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                dev_cs_d[i] = (cur_idx == IW'(i));
            end
        end
        if (state_next == ST_ASSERT_DTACK) begin
            dtack_d = 1'b1;
        end
`ifdef ZORRO_SLAVE_TIMEOUT_EN
        if (state_next == ST_BUS_ERROR) begin
            berr_d = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_zorro_slave_access.sv
// ---------------------------------------------------------------------------
// tb_zorro_slave_access
// Transaction-level bench: each bus cycle is described by address, enables,
// ack arrival edge and strobe release edge. The expected output changes are
// derived arithmetically from those numbers and queued; a monitor pops one
// expectation every time the output tuple changes.
// ---------------------------------------------------------------------------
module tb_zorro_slave_access;

    localparam int NR    = 2;
    localparam int T_CYC = 8;
`ifdef ZORRO_SLAVE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [6:0] ADDR = '0;
    logic       FCS_n = 1'b1;
    logic       slave_cycle = 1'b0;
    logic       configured = 1'b0;
    logic [1:0] ACK_n = '1;
    logic [1:0] dev_cs;
    logic [0:0] active_region;
    logic       dtack;
    logic       berr;

    zorro_slave_access #(
        .NUM_REGIONS    (2),
        .ADDR_HI        (23),
        .ADDR_LO        (17),
        .REGION_BASE    ({7'h44, 7'h40}),
        .REGION_SIZE    ({7'h02, 7'h04}),
        .REGION_WAIT    ({4'd2, 4'd0}),
        .TIMEOUT_CYCLES (T_CYC)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .ADDR          (ADDR),
        .FCS_n         (FCS_n),
        .slave_cycle   (slave_cycle),
        .configured    (configured),
        .ACK_n         (ACK_n),
        .dev_cs        (dev_cs),
        .active_region (active_region),
        .dtack         (dtack),
        .berr          (berr)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         e;
        logic [1:0] cs;
        logic       dt;
        logic       be;
        logic       rg;
    } evt_t;

    evt_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    int rb[2] = '{'h40, 'h44};
    int rs[2] = '{4, 2};
    int rw[2] = '{0, 2};

    function automatic void push(input int e, input logic [1:0] cs, input logic dt,
                                 input logic be, input logic rg);
        evt_t x;
        x.e = e; x.cs = cs; x.dt = dt; x.be = be; x.rg = rg;
        q.push_back(x);
    endfunction

    // One bus cycle. a: edge (relative to the strobe's first low sample) from
    // which the selected ack is sampled low; r: edge where the strobe is
    // sampled high; rk>0: reset sampled at that edge instead of a release.
    task automatic run_txn(input logic [6:0] addr, input logic cfg, input logic sc,
                           input int a, input int r, input int rk);
        int         base, reg_i, d, rr, g;
        bit         hit, dt, toh;
        logic [1:0] cs;
        hit = 0;
        reg_i = 0;
        for (int i = 0; i < NR; i++) begin
            if (!hit && cfg && sc && int'(addr) >= rb[i] && int'(addr) < rb[i] + rs[i]) begin
                hit = 1;
                reg_i = i;
            end
        end
        @(negedge CLK);
        base = cyc + 1;
        rr = (rk > 0) ? rk + 1 : r;
        if (hit) begin
            cs = 2'b01 << reg_i;
            d = (rw[reg_i] + 1 > a) ? rw[reg_i] + 1 : a;
            push(base, cs, 1'b0, 1'b0, reg_i[0]);
            if (rk > 0) begin
                if (d < rk) push(base + d, cs, 1'b1, 1'b0, reg_i[0]);
                push(base + rk, 2'b00, 1'b0, 1'b0, 1'b0);
            end else begin
                dt  = (d < r) && (!TO_EN || d <= T_CYC);
                toh = TO_EN && !dt && (T_CYC < r);
                if (dt)  push(base + d, cs, 1'b1, 1'b0, reg_i[0]);
                if (toh) push(base + T_CYC, 2'b00, 1'b0, 1'b1, 1'b0);
                push(base + r, 2'b00, 1'b0, 1'b0, 1'b0);
            end
        end
        for (int rel = 0; rel <= rr; rel++) begin
            if (rel > 0) @(negedge CLK);
            ACK_n = 2'($urandom);
            if (hit) ACK_n[reg_i] = (rel >= a) ? 1'b0 : 1'b1;
            if (rel == 0) begin
                ADDR = addr;
                configured = cfg;
                slave_cycle = sc;
            end else if (hit) begin
                ADDR = 7'($urandom);
                configured = 1'($urandom);
                slave_cycle = 1'($urandom);
            end
            FCS_n = (rel >= rr);
            RESET = (rk > 0 && rel == rk);
        end
        g = $urandom_range(1, 3);
        repeat (g) begin
            @(negedge CLK);
            ACK_n = '1;
            FCS_n = 1'b1;
            RESET = 1'b0;
        end
    endtask

    // Monitor: every change of the visible outputs must match the next
    // queued expectation, including the edge at which it happened.
    initial begin : monitor
        logic [3:0] prev, cur;
        evt_t       x;
        prev = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (mon_en) begin
                cur = {dev_cs, dtack, berr};
                if (cur !== prev) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change edge=%0d got cs=%b dtack=%b berr=%b",
                                 cyc, dev_cs, dtack, berr);
                    end else begin
                        x = q.pop_front();
                        if (cyc != x.e || dev_cs !== x.cs || dtack !== x.dt || berr !== x.be ||
                            (x.cs != 2'b00 && active_region[0] !== x.rg)) begin
                            errors++;
                            $display("FAIL output_change got edge=%0d cs=%b dtack=%b berr=%b reg=%b; want edge=%0d cs=%b dtack=%b berr=%b reg=%b",
                                     cyc, dev_cs, dtack, berr, active_region, x.e, x.cs, x.dt, x.be, x.rg);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    task automatic check_idle(input string name);
        checks++;
        if (dev_cs !== 2'b00 || dtack !== 1'b0 || berr !== 1'b0) begin
            errors++;
            $display("FAIL %s got cs=%b dtack=%b berr=%b want all zero", name, dev_cs, dtack, berr);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_idle("reset_state");
        RESET = 1'b0;
        @(negedge CLK);
        check_idle("after_reset_release");
        mon_en = 1;

        // Directed cycles
        run_txn(7'h41, 1'b1, 1'b1, 0, 5, 0);     // wait 0, ack ready
        run_txn(7'h44, 1'b1, 1'b1, 0, 6, 0);     // wait 2, other ack toggles
        run_txn(7'h45, 1'b1, 1'b1, 6, 9, 0);     // late ack
        run_txn(7'h40, 1'b1, 1'b1, 3, 3, 0);     // release and ack on same edge
        run_txn(7'h46, 1'b1, 1'b1, 0, 10, 0);    // no window
        run_txn(7'h41, 1'b0, 1'b1, 0, 10, 0);    // not configured
        run_txn(7'h41, 1'b1, 1'b0, 0, 10, 0);    // not our cycle
        run_txn(7'h43, 1'b1, 1'b1, 8, 12, 0);    // ack on timeout edge
        run_txn(7'h44, 1'b1, 1'b1, 1000000, 1000, 0); // ack never arrives

        // Randomized cycles
        for (int n = 0; n < 60; n++) begin
            run_txn(7'($urandom_range('h3e, 'h47)), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 7) != 0), $urandom_range(0, 12),
                    $urandom_range(1, 16), 0);
        end

        // Reset while dtack is asserted, then a normal cycle restarts
        run_txn(7'h41, 1'b1, 1'b1, 0, 0, 4);
        run_txn(7'h44, 1'b1, 1'b1, 0, 6, 0);

        repeat (5) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got %0d left want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
